// File: rtl/detect_seq_if.sv
// Signal bundle between the shot sequencer and its surroundings: shot control, config,
// DA/AD pins and the captured-sample stream. The slave side is the sequencer itself.
interface detect_seq_if #(
  parameter int unsigned DW = 8
);
  logic          start;
  logic          abort;
  logic [7:0]    cfg_tx_cycles;
  logic [3:0]    cfg_tx_half;
  logic [15:0]   cfg_delay;
  logic [11:0]   cfg_cap_len;
  logic [DW-1:0] da_data;
  logic          da_en;
  logic [DW-1:0] ad_data;
  logic          ad_valid;
  logic [DW-1:0] cap_data;
  logic          cap_valid;
  logic          cap_ready;
  logic          cap_last;
  logic          busy;
  logic          done;
  logic          overrun;

  modport master (
    output start, abort, cfg_tx_cycles, cfg_tx_half, cfg_delay, cfg_cap_len,
    output ad_data, ad_valid, cap_ready,
    input  da_data, da_en, cap_data, cap_valid, cap_last, busy, done, overrun
  );

  modport slave (
    input  start, abort, cfg_tx_cycles, cfg_tx_half, cfg_delay, cfg_cap_len,
    input  ad_data, ad_valid, cap_ready,
    output da_data, da_en, cap_data, cap_valid, cap_last, busy, done, overrun
  );
endinterface

// File: rtl/detect_seq_ctrl.sv
// One measurement shot: square-wave burst on the DA, programmable gap, then a gated
// window of AD samples presented on a one-deep valid/ready output register.
module detect_seq_ctrl #(
  parameter int unsigned   DW      = 8,
  parameter logic [DW-1:0] DA_HIGH = 8'hFF,
  parameter logic [DW-1:0] DA_LOW  = 8'h00,
  parameter logic [DW-1:0] DA_IDLE = 8'h80
) (
  input logic        clk,
  input logic        rst,
  detect_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StTx, StWait, StCap, StDrain, StDone} state_e;

  state_e        state_q;
  logic [3:0]    half_cfg_q;
  logic [3:0]    half_cnt_q;
  logic [7:0]    per_cnt_q;
  logic          phase_lo_q;
  logic [15:0]   delay_cnt_q;
  logic [11:0]   samp_cnt_q;
  logic [DW-1:0] da_data_q;
  logic          da_en_q;
  logic [DW-1:0] cap_data_q;
  logic          cap_valid_q;
  logic          cap_last_q;
  logic          overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      half_cfg_q  <= '0;
      half_cnt_q  <= '0;
      per_cnt_q   <= '0;
      phase_lo_q  <= 1'b0;
      delay_cnt_q <= '0;
      samp_cnt_q  <= '0;
      da_data_q   <= DA_IDLE;
      da_en_q     <= 1'b0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A consumed beat empties the output register unless CAP reloads it below.
      if (cap_valid_q && bus.cap_ready) begin
        cap_valid_q <= 1'b0;
        cap_last_q  <= 1'b0;
      end
      if (state_q != StIdle && bus.abort) begin
        state_q     <= StIdle;
        da_data_q   <= DA_IDLE;
        da_en_q     <= 1'b0;
        cap_valid_q <= 1'b0;
        cap_last_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.start) begin
              half_cfg_q  <= bus.cfg_tx_half;
              half_cnt_q  <= bus.cfg_tx_half;
              per_cnt_q   <= bus.cfg_tx_cycles;
              phase_lo_q  <= 1'b0;
              delay_cnt_q <= bus.cfg_delay;
              samp_cnt_q  <= bus.cfg_cap_len;
              overrun_q   <= 1'b0;
              if (bus.cfg_tx_cycles != '0) begin
                state_q   <= StTx;
                da_data_q <= DA_HIGH;
                da_en_q   <= 1'b1;
              end else if (bus.cfg_delay != '0) begin
                state_q <= StWait;
              end else if (bus.cfg_cap_len != '0) begin
                state_q <= StCap;
              end else begin
                state_q <= StDone;
              end
            end
          end
          StTx: begin
            if (half_cnt_q != '0) begin
              half_cnt_q <= half_cnt_q - 4'd1;
            end else begin
              half_cnt_q <= half_cfg_q;
              if (!phase_lo_q) begin
                phase_lo_q <= 1'b1;
                da_data_q  <= DA_LOW;
              end else if (per_cnt_q > 8'd1) begin
                per_cnt_q  <= per_cnt_q - 8'd1;
                phase_lo_q <= 1'b0;
                da_data_q  <= DA_HIGH;
              end else begin
                per_cnt_q <= '0;
                da_data_q <= DA_IDLE;
                da_en_q   <= 1'b0;
                if (delay_cnt_q != '0) begin
                  state_q <= StWait;
                end else if (samp_cnt_q != '0) begin
                  state_q <= StCap;
                end else begin
                  state_q <= StDone;
                end
              end
            end
          end
          StWait: begin
            if (delay_cnt_q > 16'd1) begin
              delay_cnt_q <= delay_cnt_q - 16'd1;
            end else begin
              delay_cnt_q <= '0;
              state_q     <= (samp_cnt_q != '0) ? StCap : StDone;
            end
          end
          StCap: begin
            if (bus.ad_valid) begin
              // Dropped samples still consume a slot of the window.
              if (!cap_valid_q || bus.cap_ready) begin
                cap_data_q  <= bus.ad_data;
                cap_valid_q <= 1'b1;
                cap_last_q  <= (samp_cnt_q == 12'd1);
              end else begin
                overrun_q <= 1'b1;
              end
              samp_cnt_q <= samp_cnt_q - 12'd1;
              if (samp_cnt_q == 12'd1) begin
                state_q <= StDrain;
              end
            end
          end
          StDrain: begin
            if (!cap_valid_q) begin
              state_q <= StDone;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.da_data   = da_data_q;
  assign bus.da_en     = da_en_q;
  assign bus.cap_data  = cap_data_q;
  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_last  = cap_last_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_detect_seq_ctrl.sv
// Bench for detect_seq_ctrl: directed shots plus random shots checked against a
// time-based shot model; captured beats go through a scoreboard queue.
module tb_detect_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  detect_seq_if #(.DW(8)) bus ();

  detect_seq_ctrl #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && bus.cap_valid === 1'b1 && bus.cap_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cap_unexpected: got %0h expected none at %0t",
                 {bus.cap_last, bus.cap_data}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cap_beat", {23'd0, bus.cap_last, bus.cap_data}, {23'd0, mon_e});
      end
    end
  end

  task automatic set_cfg(input int tx, input int h, input int d, input int n);
    bus.cfg_tx_cycles = 8'(tx);
    bus.cfg_tx_half   = 4'(h);
    bus.cfg_delay     = 16'(d);
    bus.cfg_cap_len   = 12'(n);
  endtask

  // rdy_mode: 0 random, 1 always ready, 2 not ready until the window is complete.
  task automatic run_shot(input int tx, input int h, input int d, input int n,
                          input int rdy_mode, input bit adv_always);
    int  len;
    int  ph;   // 0 tx/wait, 1 capture, 2 drain, 3 done, 4 back in idle
    int  cnt;
    bit  occ;
    bit  ovr;
    bit  fin;
    logic [7:0] ed;
    len = tx * 2 * (h + 1);
    ph = 0; cnt = 0; occ = 1'b0; ovr = 1'b0; fin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    set_cfg(tx, h, d, n);
    bus.ad_valid  = 1'b0;
    bus.cap_ready = 1'b0;
    @(negedge clk);
    chk("busy_before_start", bus.busy, 0);
    for (int k = 1; k < 5000 && !fin; k++) begin
      if (ph == 0 && k > len + d) ph = (n == 0) ? 3 : 1;
      @(posedge clk); #1;
      bus.start = (ph != 4) && ($urandom_range(3) == 0);
      set_cfg($urandom_range(255), $urandom_range(15), $urandom_range(65535),
              $urandom_range(4095));
      bus.ad_data  = 8'($urandom);
      bus.ad_valid = adv_always ? 1'b1 : 1'($urandom_range(1));
      case (rdy_mode)
        0:       bus.cap_ready = 1'($urandom_range(1));
        1:       bus.cap_ready = 1'b1;
        default: bus.cap_ready = (ph >= 2);
      endcase
      @(negedge clk);
      if (k <= len) ed = ((((k - 1) / (h + 1)) % 2) == 0) ? 8'hFF : 8'h00;
      else ed = 8'h80;
      chk("da_data", bus.da_data, ed);
      chk("da_en", bus.da_en, k <= len);
      chk("busy", bus.busy, ph != 4);
      chk("done", bus.done, ph == 3);
      chk("cap_valid", bus.cap_valid, occ);
      chk("overrun", bus.overrun, ovr);
      case (ph)
        1: begin
          if (bus.ad_valid) begin
            cnt++;
            if (!occ || bus.cap_ready) begin
              exp_q.push_back({(cnt == n), bus.ad_data});
              occ = 1'b1;
            end else begin
              ovr = 1'b1;
            end
            if (cnt == n) ph = 2;
          end else if (occ && bus.cap_ready) begin
            occ = 1'b0;
          end
        end
        2: begin
          if (!occ) ph = 3;
          else if (bus.cap_ready) occ = 1'b0;
        end
        3: ph = 4;
        4: fin = 1'b1;
        default: ;
      endcase
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL shot_timeout: got phase %0d expected shot end", ph);
    end
    bus.start     = 1'b0;
    bus.ad_valid  = 1'b0;
    bus.cap_ready = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    bus.ad_data   = '0;
    bus.ad_valid  = 1'b0;
    bus.cap_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_da_data", bus.da_data, 8'h80);
    chk("rst_da_en", bus.da_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cap_valid", bus.cap_valid, 0);
    chk("rst_cap_last", bus.cap_last, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst = 1'b0;

    // Nominal shot: 2 burst periods, 3-cycle gap, 4 samples, always ready.
    run_shot(2, 1, 3, 4, 1, 1'b1);

    // Consumer stalled during the window: one sample held, two dropped.
    run_shot(1, 0, 1, 3, 2, 1'b1);
    @(negedge clk);
    chk("overrun_sticky", bus.overrun, 1);
    run_shot(1, 0, 0, 2, 1, 1'b1);

    // Everything skipped: start goes straight to DONE.
    run_shot(0, 0, 0, 0, 0, 1'b0);

    // Abort while waiting, with start in the same cycle.
    @(posedge clk); #1;
    bus.start = 1'b1;
    set_cfg(1, 0, 10, 2);
    bus.ad_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("abort_busy_before", bus.busy, 1);
    @(posedge clk); #1;
    bus.abort    = 1'b0;
    bus.start    = 1'b0;
    bus.ad_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_da_data", bus.da_data, 8'h80);
    chk("abort_da_en", bus.da_en, 0);
    chk("abort_cap_valid", bus.cap_valid, 0);
    run_shot(1, 1, 2, 3, 0, 1'b0);

    // Random shots with random config, valid and ready patterns.
    for (int s = 0; s < 20; s++) begin
      run_shot($urandom_range(3), $urandom_range(3), $urandom_range(5), $urandom_range(6),
               $urandom_range(1) == 0 ? 0 : 1, 1'($urandom_range(1)));
    end

    // Asynchronous reset in the middle of a long burst.
    @(posedge clk); #1;
    bus.start = 1'b1;
    set_cfg(200, 3, 5, 5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_da_en", bus.da_en, 1);
    rst = 1'b1;
    #1;
    chk("midtx_rst_da_data", bus.da_data, 8'h80);
    chk("midtx_rst_da_en", bus.da_en, 0);
    chk("midtx_rst_busy", bus.busy, 0);
    chk("midtx_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_done", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
